// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_if
//  Description : Request/result bundle for the bit-serial add/subtract unit.
//                The master issues operands and the start request; the slave
//                returns status and the result flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder (with leaf full_adder)
//  Description : Bit-serial add/subtract unit. One full adder plus a carry
//                flop processes WIDTH-bit operands LSB first, one bit per
//                clock, producing sum, carry_out and signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================

module full_adder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    serial_adder_if.slave       bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-1:0]   res;
    logic [CNT_W-1:0]   cnt;
    logic               cy;
    logic               co;
    logic               ov;

    logic               fa_s;
    logic               fa_c;
    logic               accept;
    logic               last_bit;

    // A new operation is accepted only outside RUN; DONE may chain directly
    assign accept   = bus.start && (state != RUN);
    assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    full_adder u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (cy),
        .s    (fa_s),
        .cout (fa_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry flop, bit counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a <= '0;
            sh_b <= '0;
            res  <= '0;
            cnt  <= '0;
            cy   <= 1'b0;
            co   <= 1'b0;
            ov   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert B and preload carry with 1
            sh_a <= bus.a;
            sh_b <= bus.b ^ {WIDTH{bus.sub}};
            cy   <= bus.sub;
            cnt  <= '0;
            res  <= '0;
            co   <= 1'b0;
            ov   <= 1'b0;
        end else if (state == RUN) begin
            // Sum bits enter from the MSB so after WIDTH shifts bit 0 is LSB
            res  <= {fa_s, res[WIDTH-1:1]};
            cy   <= fa_c;
            sh_a <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b <= {1'b0, sh_b[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
            if (last_bit) begin
                // cy still holds the carry into the MSB at this point
                co <= fa_c;
                ov <= cy ^ fa_c;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.sum       = res;
    assign bus.carry_out = co;
    assign bus.overflow  = ov;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Scoreboard bench for serial_adder (WIDTH=16) using directed
//                vectors with hand-computed results and done-cycle timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic [31:0] edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge counter used to check done timing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop one expectation per done pulse
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum",       {16'h0, bus.sum},       {16'h0, e.s});
                chk("carry_out", {31'h0, bus.carry_out}, {31'h0, e.co});
                chk("overflow",  {31'h0, bus.overflow},  {31'h0, e.ov});
                chk("done_cycle", cyc, e.edge_n);
            end
        end
    end

    task automatic push_exp(input logic [15:0] s, input logic co, input logic ov);
        exp_t e;
        e.s = s; e.co = co; e.ov = ov;
        // start is sampled at the next edge (cyc+1); done shows WIDTH edges later
        e.edge_n = cyc + 1 + WIDTH;
        sb.push_back(e);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d results pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         input logic [15:0] es, input logic eco, input logic eov);
        @(negedge clk);
        bus.a = ta; bus.b = tb_; bus.sub = ts; bus.start = 1'b1;
        push_exp(es, eco, eov);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_run", {31'h0, bus.busy}, 32'h1);
        wait_empty();
        @(negedge clk);
        chk("sum_hold", {16'h0, bus.sum}, {16'h0, es});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'h0, bus.busy},      32'h0);
        chk({tag, "_done"}, {31'h0, bus.done},      32'h0);
        chk({tag, "_sum"},  {16'h0, bus.sum},       32'h0);
        chk({tag, "_co"},   {31'h0, bus.carry_out}, 32'h0);
        chk({tag, "_ov"},   {31'h0, bus.overflow},  32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("idle");

        // Basic add, carry and overflow cases, subtraction
        do_op(16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

        // start during RUN with new operands must be ignored
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h0FED; bus.sub = 1'b0; bus.start = 1'b1;
        push_exp(16'h2221, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.a = 16'hAAAA; bus.b = 16'h1111; bus.sub = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_empty();
        repeat (2) @(negedge clk);

        // start held high: three back-to-back operations, 17 cycles apart
        @(negedge clk);
        bus.a = 16'h0001; bus.b = 16'h0002; bus.sub = 1'b0; bus.start = 1'b1;
        push_exp(16'h0003, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        bus.a = 16'h00FF; bus.b = 16'h0001; bus.sub = 1'b0;
        push_exp(16'h0100, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        bus.a = 16'h0003; bus.b = 16'h0001; bus.sub = 1'b1;
        push_exp(16'h0002, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_empty();
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN aborts with no done pulse
        @(negedge clk);
        bus.a = 16'h5555; bus.b = 16'h1111; bus.sub = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial add/subtract unit built around a single full_adder instance, plus a registered carry flip-flop.
- Processes WIDTH-bit operands LSB first, one bit per clock, and produces a WIDTH-bit result with carry and overflow flags.
- It is the sequential consumer stage of full_adder: it feeds the adder a, b and the carry-in each cycle, and captures the carry and sum it produces.
- Serves as a low-area alternative to the ripple add16 in the ALU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an operation; sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; holds its value until the next accepted start.
- carry_out  output  1  final carry out of the MSB; for subtraction, 1 means no borrow.
- overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- While rst_n=0 the block is in IDLE and busy=0, done=0, sum=0, carry_out=0, overflow=0, the bit counter is 0 and the carry flop is 0.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 at a clock edge:
  - load shift register A with a.
  - load shift register B with b XOR {WIDTH{sub}}.
  - set the carry flop to sub.
  - clear the counter and the result register.
  - go to RUN; busy=1 from the next cycle.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - the full_adder inputs are A[0], B[0] and the carry flop.
  - the adder's sum bit shifts into the result register from the MSB side (right shift), so after WIDTH shifts the bit order is correct.
  - the adder's carry is registered into the carry flop.
  - A and B shift right by one.
  - the counter increments.
- On the RUN cycle where counter = WIDTH-1:
  - also capture carry_out = adder carry.
  - capture overflow = (carry flop before the update) XOR (adder carry).
  - go to DONE.
- DONE lasts exactly one cycle: done=1, busy=0.
- sum, carry_out and overflow are valid from that cycle and hold until the next accepted start.
- Latency: start sampled at edge N → done=1 during the cycle after edge N+WIDTH. For WIDTH=16, done is high 16 cycles after the start edge.
- start while busy=1 is ignored; operands and sub are not re-sampled.
- start held high continuously gives back-to-back operations: a new start is accepted in the DONE cycle, so throughput is one result per WIDTH+1 cycles.
- Arithmetic is modulo 2^WIDTH, with no saturation.
  - a-b is computed as a + ~b + 1.
  - 0 - 0 gives sum=0 and carry_out=1.
- During RUN, sum shows the partial shift contents and is not valid; it is only meaningful once done has pulsed.
- rst_n asserted mid-RUN: the operation is aborted immediately. All outputs return to reset values, no done pulse is produced, and the block is ready in IDLE after rst_n deasserts.
- Counter width is $clog2(WIDTH)+1 bits; the counter never wraps within an operation.

Test Plan:
- Reset/idle: assert rst_n=0 mid-idle → busy=0, done=0, sum=0x0000, carry_out=0, overflow=0; release with start=0 → all outputs stay 0.
- Basic add: a=0x1234, b=0x0FED, sub=0, pulse start → busy high for 16 cycles, done pulses once 16 cycles after start, sum=0x2221, carry_out=0, overflow=0.
- Carry/overflow add:
  - a=0xFFFF, b=0x0001 → sum=0x0000, carry_out=1, overflow=0.
  - a=0x7FFF, b=0x0001 → sum=0x8000, carry_out=0, overflow=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, carry_out=0 (borrow), overflow=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, overflow=1.
- Handshake: start asserted again at cycle 5 of RUN with different operands → ignored, and the original result is reported. start held high for 3 operations → done pulses every 17 cycles with the correct results.
- Reset mid-operation: pull rst_n low at cycle 8 of RUN, release, start a=0x0003 and b=0x0004 → no stale done pulse, then sum=0x0007 after 16 cycles.
